hw_fifo_mon: RTL and testbench

Parametrised synchronous FIFO for the image pixel path: a successor to the team's basic push/pop FIFO. It adds run-time programmable almost-full/almost-empty thresholds, an occupancy count, a high-water mark, a synchronous flush, and sticky overflow/underflow error flags. It sits between line-buffer/filter stages, where the controller needs occupancy visibility and error detection rather than silent misuse.

---
 rtl/hw_fifo_mon.sv | 144 ++++++++++++++
 tb/tb_hw_fifo_mon.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hw_fifo_mon.sv
// rtl/hw_fifo_mon.sv - synchronous FWFT FIFO with thresholds, occupancy, high-water mark and sticky errors
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   flush              synchronous empty; discards contents, leaves sticky flags and peak alone
//   wr_push, wr_data   write request and word
//   wr_full            count == DEPTH
//   wr_almost_full     free entries <= cfg_afull
//   rd_pop             read request; rd_data is consumed on this edge
//   rd_data            front word, first-word fall-through
//   rd_empty           count == 0
//   rd_almost_empty    count <= cfg_aempty
//   cfg_afull          almost-full threshold in free entries
//   cfg_aempty         almost-empty threshold in valid entries
//   count, peak        current occupancy and highest occupancy since reset/err_clr
//   overflow           sticky: push while full
//   underflow          sticky: pop while empty
//   err_clr            clears overflow/underflow, reloads peak with the next count
module hw_fifo_mon #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            wr_push,
  input  logic [DATA-1:0] wr_data,
  output logic            wr_full,
  output logic            wr_almost_full,
  input  logic            rd_pop,
  output logic [DATA-1:0] rd_data,
  output logic            rd_empty,
  output logic            rd_almost_empty,
  input  logic [ADDR:0]   cfg_afull,
  input  logic [ADDR:0]   cfg_aempty,
  output logic [ADDR:0]   count,
  output logic [ADDR:0]   peak,
  output logic            overflow,
  output logic            underflow,
  input  logic            err_clr
);

  localparam int            DEPTH   = 1 << ADDR;
  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  logic [DATA-1:0] mem [DEPTH];

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic [ADDR:0]   peak_q, peak_d;
  logic            wr_full_q, wr_full_d;
  logic            wr_almost_full_q, wr_almost_full_d;
  logic            rd_empty_q, rd_empty_d;
  logic            rd_almost_empty_q, rd_almost_empty_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic          pop_eff, push_eff;
  logic          ovf_ev, udf_ev;
  logic [ADDR:0] free_d;

  always_comb begin
    // A pop frees a slot in the same edge, so a full FIFO still accepts a
    // simultaneous push. flush suppresses both requests and their errors.
    pop_eff  = rd_pop & ~rd_empty_q & ~flush;
    push_eff = wr_push & (~wr_full_q | pop_eff) & ~flush;
    ovf_ev   = wr_push & ~push_eff & ~flush;
    udf_ev   = rd_pop & rd_empty_q & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Flags are derived from the next count so they line up with count.
    free_d            = DEPTH_W - count_d;
    wr_full_d         = (count_d == DEPTH_W);
    rd_empty_d        = (count_d == '0);
    wr_almost_full_d  = (free_d <= cfg_afull);
    rd_almost_empty_d = (count_d <= cfg_aempty);

    if (err_clr) peak_d = count_d;
    else         peak_d = (count_d > peak_q) ? count_d : peak_q;

    // An error in the same cycle as err_clr must survive the clear.
    overflow_d  = ovf_ev | (overflow_q & ~err_clr);
    underflow_d = udf_ev | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      peak_q            <= '0;
      wr_full_q         <= 1'b0;
      wr_almost_full_q  <= 1'b0;
      rd_empty_q        <= 1'b1;
      rd_almost_empty_q <= 1'b1;
      overflow_q        <= 1'b0;
      underflow_q       <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      peak_q            <= peak_d;
      wr_full_q         <= wr_full_d;
      wr_almost_full_q  <= wr_almost_full_d;
      rd_empty_q        <= rd_empty_d;
      rd_almost_empty_q <= rd_almost_empty_d;
      overflow_q        <= overflow_d;
      underflow_q       <= underflow_d;
    end
  end

  // Storage is not reset; only the write port is clocked.
  always_ff @(posedge clk) begin
    if (rst_n && push_eff) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data         = mem[rd_ptr_q];
  assign count           = count_q;
  assign peak            = peak_q;
  assign wr_full         = wr_full_q;
  assign wr_almost_full  = wr_almost_full_q;
  assign rd_empty        = rd_empty_q;
  assign rd_almost_empty = rd_almost_empty_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_hw_fifo_mon.sv
// tb/tb_hw_fifo_mon.sv - scoreboard bench for hw_fifo_mon with a queue-based reference model
module tb_hw_fifo_mon;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr_push, rd_pop, err_clr;
  logic [7:0] wr_data, rd_data;
  logic       wr_full, wr_almost_full, rd_empty, rd_almost_empty;
  logic [4:0] cfg_afull, cfg_aempty, count, peak;
  logic       overflow, underflow;

  always #5 clk = ~clk;

  hw_fifo_mon #(.DATA(8), .ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_push(wr_push), .wr_data(wr_data),
    .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .rd_pop(rd_pop), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty),
    .cfg_afull(cfg_afull), .cfg_aempty(cfg_aempty),
    .count(count), .peak(peak),
    .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  typedef struct {
    int       cnt;
    int       pk;
    bit       full, empty, afull, aempty, ov, un;
    bit       has_front;
    bit [7:0] front;
  } st_t;

  st_t      st_q[$];
  bit [7:0] sb_q[$];
  bit [7:0] mq[$];
  bit       m_ov, m_un;
  int       m_pk;
  int       n_cmp = 0;
  int       n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus, advances the reference model and queues
  // the expected post-edge state for the monitor.
  task automatic step(bit rst, bit fl, bit push, bit pop, bit [7:0] d, bit clr);
    st_t e;
    int  n;
    bit  popok, pushok, ovev, unev;
    rst_n = rst; flush = fl; wr_push = push; rd_pop = pop; wr_data = d; err_clr = clr;
    ovev = 0; unev = 0;
    if (!rst) begin
      mq.delete();
      m_ov = 0; m_un = 0; m_pk = 0;
    end else begin
      if (fl) mq.delete();
      else begin
        popok  = pop && (mq.size() > 0);
        pushok = push && (mq.size() < DEPTH || popok);
        ovev   = push && !pushok;
        unev   = pop && (mq.size() == 0);
        if (popok) begin
          sb_q.push_back(mq[0]);
          void'(mq.pop_front());
        end
        if (pushok) mq.push_back(d);
      end
      n = mq.size();
      if (clr) begin m_ov = 0; m_un = 0; m_pk = n; end
      else if (n > m_pk) m_pk = n;
      if (ovev) m_ov = 1;
      if (unev) m_un = 1;
    end
    n       = mq.size();
    e.cnt   = n;
    e.pk    = m_pk;
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.afull  = rst ? ((DEPTH - n) <= int'(cfg_afull)) : 1'b0;
    e.aempty = rst ? (n <= int'(cfg_aempty)) : 1'b1;
    e.ov    = m_ov;
    e.un    = m_un;
    e.has_front = (n > 0);
    e.front = (n > 0) ? mq[0] : 8'h00;
    st_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 0, 8'h00, 0);
  endtask

  // Monitor: checks state on the falling edge, away from the active edge.
  st_t m_e;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      m_e = st_q.pop_front();
      chk("count", int'(count), m_e.cnt);
      chk("peak", int'(peak), m_e.pk);
      chk("wr_full", int'(wr_full), int'(m_e.full));
      chk("rd_empty", int'(rd_empty), int'(m_e.empty));
      chk("wr_almost_full", int'(wr_almost_full), int'(m_e.afull));
      chk("rd_almost_empty", int'(rd_almost_empty), int'(m_e.aempty));
      chk("overflow", int'(overflow), int'(m_e.ov));
      chk("underflow", int'(underflow), int'(m_e.un));
      if (m_e.has_front) chk("rd_data_front", int'(rd_data), int'(m_e.front));
    end
    if (rst_n === 1'b1 && flush === 1'b0 && rd_pop === 1'b1 && rd_empty === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_data: DUT presented %0d with no expected word queued", rd_data);
      end else begin
        chk("pop_data", int'(rd_data), int'(sb_q.pop_front()));
      end
    end
  end

  int p_push, p_pop;

  initial begin
    cfg_afull = 5'd2;
    cfg_aempty = 5'd3;
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    idle(1);

    // Fill with 0x01..0x10, overflow push, then drain in order.
    for (int i = 1; i <= 16; i++) step(1, 0, 1, 0, 8'(i), 0);
    step(1, 0, 1, 0, 8'hFF, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 1, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 1);

    // Almost-empty threshold change at count 4.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'(8'h40 + i), 0);
    cfg_aempty = 5'd5;
    idle(1);
    cfg_aempty = 5'd3;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 1);

    // Pop on empty with simultaneous push.
    step(1, 0, 1, 1, 8'hA5, 0);
    idle(1);
    step(1, 0, 0, 1, 8'h00, 1);

    // Full FIFO, 40 cycles of push+pop across pointer wrap.
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 8'(8'h80 + i), 0);
    for (int i = 0; i < 40; i++) step(1, 0, 1, 1, 8'(8'h90 + i), 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 8'h00, 0);

    // Count 9 then flush with push; then err_clr.
    step(1, 0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 8'(8'h20 + i), 0);
    step(1, 1, 1, 1, 8'h77, 0);
    step(1, 0, 0, 0, 8'h00, 1);

    // Reset at count 7, then a round trip.
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 8'(8'h30 + i), 0);
    step(0, 0, 1, 0, 8'h55, 0);
    step(1, 0, 1, 0, 8'h66, 0);
    step(1, 0, 0, 1, 8'h00, 0);

    // Randomised phase with biased push/pop rates.
    p_push = 50; p_pop = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) begin
        p_push = 20 + 30 * $urandom_range(0, 2);
        p_pop  = 20 + 30 * $urandom_range(0, 2);
      end
      if ($urandom_range(0, 49) == 0) cfg_afull  = 5'($urandom_range(0, 17));
      if ($urandom_range(0, 49) == 0) cfg_aempty = 5'($urandom_range(0, 17));
      step($urandom_range(0, 399) != 0,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < p_push,
           $urandom_range(0, 99) < p_pop,
           8'($urandom),
           $urandom_range(0, 99) < 3);
    end

    idle(1);
    @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    chk("st_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
